// File: rtl/psum_acc_seq_pkg.sv
// psum_acc_pkg: state encoding and counter width helper for the accumulation sequencer
package psum_acc_pkg;
  typedef enum logic [2:0] {IDLE, READ, WAIT, RELU, WRITE, DONE} state_t;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/psum_acc_seq_if.sv
// psum_acc_seq_if: control, psum SRAM, sfu and output SRAM signals of the sequencer
interface psum_acc_seq_if #(
  parameter int COL = 8,
  parameter int PSUM_BW = 16,
  parameter int ADDR_W = 11
);
  localparam int W = COL * PSUM_BW;
  logic start, busy, done;
  logic pmem_cen, sfu_acc, sfu_relu, omem_wen;
  logic [ADDR_W-1:0] pmem_addr, omem_addr;
  logic [W-1:0] pmem_q, sfu_psum_in, sfu_psum_out, omem_d;
  modport master (
    input start, pmem_q, sfu_psum_out,
    output busy, done, pmem_cen, pmem_addr, sfu_acc, sfu_relu, sfu_psum_in,
    output omem_wen, omem_addr, omem_d
  );
  modport slave (
    output start, pmem_q, sfu_psum_out,
    input busy, done, pmem_cen, pmem_addr, sfu_acc, sfu_relu, sfu_psum_in,
    input omem_wen, omem_addr, omem_d
  );
endinterface

// File: rtl/psum_acc_seq_addr_gen.sv
// psum_acc_addr_gen: kij/o counters with a running kij*N_O+o address built by repeated adds
module psum_acc_addr_gen import psum_acc_pkg::*; #(
  parameter int ADDR_W = 11,
  parameter int N_KIJ = 9,
  parameter int N_O = 16,
  localparam int KW = clog2_min1(N_KIJ),
  localparam int OW = clog2_min1(N_O)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              step_kij,
  input  logic              next_o,
  output logic [ADDR_W-1:0] addr,
  output logic [OW-1:0]     o,
  output logic              last_kij,
  output logic              last_o
);
  logic [KW-1:0] kij;
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      kij <= '0;
      o <= '0;
      addr <= '0;
    end else if (step_kij) begin
      kij <= kij + KW'(1);
      addr <= addr + ADDR_W'(N_O);
    end else if (next_o) begin
      kij <= '0;
      o <= o + OW'(1);
      addr <= ADDR_W'(o) + ADDR_W'(1);
    end
  end
  assign last_kij = kij == KW'(N_KIJ - 1);
  assign last_o = o == OW'(N_O - 1);
endmodule

// File: rtl/psum_acc_seq.sv
// psum_acc_seq: streams N_KIJ psum rows per pixel into the sfu, applies relu, writes output SRAM
module psum_acc_seq import psum_acc_pkg::*; #(
  parameter int COL = 8,
  parameter int PSUM_BW = 16,
  parameter int ADDR_W = 11,
  parameter int N_KIJ = 9,
  parameter int N_O = 16
) (
  input logic clk,
  input logic reset,
  psum_acc_seq_if.master bus
);
  localparam int W = COL * PSUM_BW;
  localparam int OW = clog2_min1(N_O);
  state_t state, nxt;
  logic rd_valid, last_kij, last_o;
  logic [OW-1:0] o;
  psum_acc_addr_gen #(.ADDR_W(ADDR_W), .N_KIJ(N_KIJ), .N_O(N_O)) u_addr_gen (
    .clk,
    .reset,
    .clr(state == IDLE && bus.start),
    .step_kij(state == READ && !last_kij),
    .next_o(state == WRITE && !last_o),
    .addr(bus.pmem_addr),
    .o,
    .last_kij,
    .last_o
  );
  // read data arrives one cycle after cen, so acc follows the read state by one cycle
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : nxt;
    rd_valid <= !reset && state == READ;
  end
  always_comb begin
    nxt = state == IDLE  ? (bus.start ? READ : IDLE)
        : state == READ  ? (last_kij ? WAIT : READ)
        : state == WAIT  ? RELU
        : state == RELU  ? WRITE
        : state == WRITE ? (last_o ? DONE : READ)
        : IDLE;
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.pmem_cen = state != READ;
  assign bus.sfu_acc = rd_valid;
  assign bus.sfu_relu = state == RELU;
  assign bus.sfu_psum_in = rd_valid ? bus.pmem_q : W'(0);
  assign bus.omem_wen = state != WRITE;
  assign bus.omem_addr = ADDR_W'(o);
  assign bus.omem_d = state == WRITE ? bus.sfu_psum_out : W'(0);
endmodule
